// File: rtl/aes_pkg.sv
// Shared AES definitions: block/word types, round count, FSM states and
// the GF(2^8) helpers used by the key schedule.
package aes_pkg;

    typedef logic [127:0] block_t;
    typedef logic [31:0]  word_t;

    localparam int AES128_ROUNDS = 10;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    // Multiply by x in GF(2^8); reduction by the AES polynomial keeps it 8 bits.
    function automatic logic [7:0] xtime(input logic [7:0] r);
        return {r[6:0], 1'b0} ^ (r[7] ? 8'h1B : 8'h00);
    endfunction

    // Cyclic left rotation of a word by one byte.
    function automatic word_t rotWord(input word_t w);
        return {w[23:0], w[31:24]};
    endfunction

endpackage

// File: rtl/aes_sbox_word.sv
// SubWord: four parallel combinational AES S-box lookups on one 32-bit word.
// Shared between the key schedule and the SubBytes stage.
module aes_sbox_word
    import aes_pkg::*;
(
    input  word_t word_i,
    output word_t word_o
);

    localparam logic [7:0] SBOX [0:255] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    // Each byte lane is an independent table lookup.
    for (genvar b = 0; b < 4; b++) begin : g_byte
        assign word_o[8*b +: 8] = SBOX[word_i[8*b +: 8]];
    end

endmodule

// File: rtl/aes_key_expander.sv
// AES-128 iterative key schedule. Holds the current round key and derives
// the next one on each consumer handshake, so no expanded-key table is kept.
module aes_key_expander
    import aes_pkg::*;
#(
    parameter int NUM_ROUNDS = AES128_ROUNDS
)
(
    input  logic         clk,
    input  logic         rst,
    input  logic         key_valid,
    output logic         key_ready,
    input  logic [127:0] key_in,
    input  logic         abort,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic [127:0] round_key,
    output logic [3:0]   round_num,
    output logic         last_round
);

    localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);

    state_t     state_q, state_d;
    block_t     roundKey_q, roundKey_d;
    logic [3:0] roundNum_q, roundNum_d;
    logic [7:0] rcon_q, rcon_d;

    logic   isLast;
    logic   keyLoad;
    logic   rkFire;
    word_t  w0, w1, w2, w3;
    word_t  subRot;
    word_t  temp;
    word_t  n0, n1, n2, n3;
    block_t nextKey;

    assign isLast  = (roundNum_q == LAST_ROUND);
    assign keyLoad = (state_q == IDLE) && key_valid && !abort;
    assign rkFire  = (state_q == ACTIVE) && rk_ready && !abort;

    // One step of the key expansion, computed from the held round key.
    assign w0 = roundKey_q[127:96];
    assign w1 = roundKey_q[95:64];
    assign w2 = roundKey_q[63:32];
    assign w3 = roundKey_q[31:0];

    aes_sbox_word u_subWord (
        .word_i (rotWord(w3)),
        .word_o (subRot)
    );

    assign temp    = subRot ^ {rcon_q, 24'h000000};
    assign n0      = w0 ^ temp;
    assign n1      = w1 ^ n0;
    assign n2      = w2 ^ n1;
    assign n3      = w3 ^ n2;
    assign nextKey = {n0, n1, n2, n3};

    // State register; reset returns to IDLE ahead of everything else.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: abort wins, otherwise load a key or finish after the last round.
    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (key_valid) state_d = ACTIVE;
                ACTIVE:  if (rk_ready && isLast) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Handshake flags follow directly from the state.
    always_comb begin
        key_ready = 1'b0;
        rk_valid  = 1'b0;
        case (state_q)
            IDLE:    key_ready = 1'b1;
            ACTIVE:  rk_valid  = 1'b1;
            default: ;
        endcase
    end

    // Datapath next values: load the cipher key, or advance one round on a handshake.
    always_comb begin
        roundKey_d = roundKey_q;
        roundNum_d = roundNum_q;
        rcon_d     = rcon_q;
        if (keyLoad) begin
            roundKey_d = key_in;
            roundNum_d = 4'd0;
            rcon_d     = 8'h01;
        end else if (rkFire && !isLast) begin
            roundKey_d = nextKey;
            roundNum_d = roundNum_q + 4'd1;
            rcon_d     = xtime(rcon_q);
        end
    end

    // Datapath registers; after the final round they simply hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            roundKey_q <= '0;
            roundNum_q <= 4'd0;
            rcon_q     <= 8'h01;
        end else begin
            roundKey_q <= roundKey_d;
            roundNum_q <= roundNum_d;
            rcon_q     <= rcon_d;
        end
    end

    assign round_key  = roundKey_q;
    assign round_num  = roundNum_q;
    assign last_round = isLast;

endmodule
